// File: rtl/sbram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : sbram_burst_reader
// Description : Burst read master for a 256x16 iCE40 block-RAM read port.
//               It takes a (start address, length-1) command, reads the RAM
//               sequentially, and returns the words on a valid/ready stream
//               through a 2-entry output FIFO. The stream sustains one word
//               per cycle and never drops a word under backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module sbram_burst_reader #(
   parameter int AW = 8,
   parameter int DW = 16
) (
   input  logic          i_clock,
   input  logic          i_reset,
   input  logic          i_cmd_valid,
   output logic          o_cmd_ready,
   input  logic [AW-1:0] i_cmd_addr,
   input  logic [AW-1:0] i_cmd_len,
   output logic          o_ram_re,
   output logic [10:0]   o_ram_raddr,
   input  logic [DW-1:0] i_ram_rdata,
   output logic          o_out_valid,
   input  logic          i_out_ready,
   output logic [DW-1:0] o_out_data,
   output logic          o_out_last,
   output logic          o_busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [AW-1:0] r_addr;
   logic [AW-1:0] r_remain;
   logic          r_infl;
   logic          r_infl_last;
   logic [1:0]    r_count;
   logic [DW-1:0] r_head_data;
   logic [DW-1:0] r_tail_data;
   logic          r_head_last;
   logic          r_tail_last;

   logic          w_pop;
   logic          w_push;
   logic          w_issue;
   logic          w_accept;
   logic [1:0]    w_occ;

   // Words committed to the buffer after this cycle: stored plus arriving
   // minus leaving. A new read is only safe while this stays below 2, which
   // is also loose enough to keep one read per cycle with the consumer ready.
   // Because it includes this cycle's pop, the read enable is decoded from
   // registered state and the consumer's ready.
   assign w_pop  = (r_count != 2'd0) && i_out_ready;
   assign w_push = r_infl;
   assign w_occ  = r_count + {1'b0, r_infl} - {1'b0, w_pop};

   assign o_cmd_ready = (r_state == S_IDLE);
   assign o_busy      = (r_state != S_IDLE);
   assign o_ram_re    = w_issue;
   assign o_ram_raddr = 11'(r_addr);
   assign o_out_valid = (r_count != 2'd0);
   assign o_out_data  = r_head_data;
   assign o_out_last  = r_head_last;

   // State register.
   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_next;
   end

   // Next-state decode, command accept and read issue under the credit limit.
   always_comb begin
      w_state_next = r_state;
      w_issue      = 1'b0;
      w_accept     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_accept = i_cmd_valid;
            if (i_cmd_valid) w_state_next = S_READ;
         end
         S_READ: begin
            w_issue = (w_occ < 2'd2);
            if (w_issue && (r_remain == '0)) w_state_next = S_DRAIN;
         end
         S_DRAIN: begin
            // Leave as soon as the last buffered word is being popped so busy
            // falls in the cycle right after that pop.
            if (!r_infl && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop)))
               w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Address counter and remaining-reads counter.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_addr   <= '0;
         r_remain <= '0;
      end else if (w_accept) begin
         r_addr   <= i_cmd_addr;
         r_remain <= i_cmd_len;
      end else if (w_issue) begin
         r_addr <= r_addr + AW'(1);
         if (r_remain != '0) r_remain <= r_remain - AW'(1);
      end
   end

   // In-flight flag: the RAM word arriving next cycle must be captured, and
   // whether it belongs to the final read of the burst.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_infl      <= 1'b0;
         r_infl_last <= 1'b0;
      end else begin
         r_infl      <= w_issue;
         r_infl_last <= w_issue && (r_remain == '0);
      end
   end

   // Two-entry output FIFO; the head entry drives the stream directly.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_count     <= 2'd0;
         r_head_data <= '0;
         r_head_last <= 1'b0;
         r_tail_data <= '0;
         r_tail_last <= 1'b0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) begin
                  r_head_data <= i_ram_rdata;
                  r_head_last <= r_infl_last;
               end else begin
                  r_tail_data <= i_ram_rdata;
                  r_tail_last <= r_infl_last;
               end
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_head_data <= r_tail_data;
               r_head_last <= r_tail_last;
               r_count     <= r_count - 2'd1;
            end
            2'b11: begin
               // Count is unchanged; with two stored the tail moves up first.
               if (r_count == 2'd2) begin
                  r_head_data <= r_tail_data;
                  r_head_last <= r_tail_last;
                  r_tail_data <= i_ram_rdata;
                  r_tail_last <= r_infl_last;
               end else begin
                  r_head_data <= i_ram_rdata;
                  r_head_last <= r_infl_last;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
